// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its two-requester arbiter:
// op-code constants, response-state encoding and the response record.
package alu_pkg;

   // ALU control codes. Codes 1000-1111 never produce a data result.
   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_AND = 4'b0001;
   localparam logic [3:0] ALU_OR  = 4'b0010;
   localparam logic [3:0] ALU_SLL = 4'b0011;
   localparam logic [3:0] ALU_SLT = 4'b0100;
   localparam logic [3:0] ALU_SRL = 4'b0101;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_XOR = 4'b0111;
   localparam logic [3:0] ALU_BEQ = 4'b1000;
   localparam logic [3:0] ALU_BNE = 4'b1001;

   // Storage width of the tag field in the response record; the arbiter's
   // TAG_W parameter must not exceed it.
   localparam int unsigned TAG_W_MAX = 4;

   // Response register occupancy.
   typedef enum logic {StEmpty, StFull} rsp_state_e;

   // One registered response.
   typedef struct packed {
      logic [31:0]          data;
      logic                 zero;
      logic                 id;
      logic [TAG_W_MAX-1:0] tag;
   } rsp_t;

   // Branch/control codes (upper half of the op space) carry no data result.
   function automatic logic is_ctrl_op(input logic [3:0] op);
      return op[3];
   endfunction

endpackage

// File: rtl/alu.sv
// Single-cycle combinational integer ALU with a branch-condition flag.
module alu
   import alu_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [3:0]  op,
   output logic [31:0] result,
   output logic        zero
);

   // Decode the op code into a result and a branch flag
   always_comb begin
      result = '0;
      zero   = 1'b0;
      case (op)
         ALU_ADD: result = a + b;
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_SLL: result = a << b[4:0];
         ALU_SLT: result = {31'b0, $signed(a) < $signed(b)};
         ALU_SRL: result = a >> b[4:0];
         ALU_SUB: result = a - b;
         ALU_XOR: result = a ^ b;
         ALU_BEQ: zero   = (a == b);
         ALU_BNE: zero   = (a != b);
         default: ;
      endcase
   end

endmodule

// File: rtl/rr_arb2.sv
// Two-input round-robin grant generator. On contention the requester that
// did not win the last transfer is chosen; all grants are gated by can_issue.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req_valid,
   input  logic       can_issue,
   output logic [1:0] grant
);

   logic last_grant_q;
   logic last_grant_d;
   logic sel;

   // Choose which requester is eligible this cycle
   always_comb begin
      unique case (req_valid)
         2'b00:   sel = 1'b0;
         2'b01:   sel = 1'b0;
         2'b10:   sel = 1'b1;
         2'b11:   sel = ~last_grant_q;
      endcase
   end

   // Grant is one-hot or zero: valid, selected and allowed to issue
   always_comb begin
      grant[0] = can_issue & req_valid[0] & ~sel;
      grant[1] = can_issue & req_valid[1] & sel;
   end

   // Remember the winner only when a transfer actually happens
   always_comb begin
      last_grant_d = last_grant_q;
      if (|grant) begin
         last_grant_d = grant[1];
      end
   end

   // Reset to 1 so requester 0 wins the first contention
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= 1'b1;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters with
// round-robin arbitration and a single registered response stage.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int unsigned TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [31:0]      req0_a,
   input  logic [31:0]      req0_b,
   input  logic [3:0]       req0_op,
   input  logic [TAG_W-1:0] req0_tag,
   input  logic [31:0]      req1_a,
   input  logic [31:0]      req1_b,
   input  logic [3:0]       req1_op,
   input  logic [TAG_W-1:0] req1_tag,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_data,
   output logic             rsp_zero,
   output logic             rsp_id,
   output logic [TAG_W-1:0] rsp_tag
);

   rsp_state_e state_q;
   rsp_state_e state_d;
   rsp_t       rsp_q;
   rsp_t       rsp_d;

   logic             can_issue;
   logic             accept;
   logic [31:0]      sel_a;
   logic [31:0]      sel_b;
   logic [3:0]       sel_op;
   logic [TAG_W-1:0] sel_tag;
   logic [31:0]      alu_result;
   logic             alu_zero;

   rr_arb2 u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .can_issue (can_issue),
      .grant     (req_ready)
   );

   assign accept = |req_ready;

   // Route the granted requester's operands to the ALU
   always_comb begin
      if (req_ready[1]) begin
         sel_a   = req1_a;
         sel_b   = req1_b;
         sel_op  = req1_op;
         sel_tag = req1_tag;
      end else begin
         sel_a   = req0_a;
         sel_b   = req0_b;
         sel_op  = req0_op;
         sel_tag = req0_tag;
      end
   end

   alu u_alu (
      .a      (sel_a),
      .b      (sel_b),
      .op     (sel_op),
      .result (alu_result),
      .zero   (alu_zero)
   );

   // Response occupancy register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StEmpty;
      end else begin
         state_q <= state_d;
      end
   end

   // Fill on accept; empty only on a drain without a refill
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StEmpty: if (accept) state_d = StFull;
         StFull:  if (rsp_ready && !accept) state_d = StEmpty;
      endcase
   end

   // Issue is allowed when empty or draining; held off entirely in reset
   always_comb begin
      rsp_valid = (state_q == StFull);
      can_issue = rst_n & ((state_q == StEmpty) | rsp_ready);
   end

   // Capture the ALU outputs on the accepting edge; control ops return zero data
   always_comb begin
      rsp_d = rsp_q;
      if (accept) begin
         rsp_d.data = is_ctrl_op(sel_op) ? 32'b0 : alu_result;
         rsp_d.zero = alu_zero;
         rsp_d.id   = req_ready[1];
         rsp_d.tag  = TAG_W_MAX'(sel_tag);
      end
   end

   // Response payload register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_q <= '0;
      end else begin
         rsp_q <= rsp_d;
      end
   end

   assign rsp_data = rsp_q.data;
   assign rsp_zero = rsp_q.zero;
   assign rsp_id   = rsp_q.id;
   assign rsp_tag  = rsp_q.tag[TAG_W-1:0];

endmodule
